// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU issue controller: op encodings, FSM states and the
// packed instruction word that travels through the issue buffer.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SRA = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_EXEC   = 2'b01,
    ST_SETTLE = 2'b10
  } issue_state_e;

  typedef struct packed {
    alu_op_e    op;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [3:0] rd;
  } instr_t;

  localparam int INSTR_W = $bits(instr_t);

  function automatic instr_t pack_instr(input logic [2:0] op, input logic [3:0] rs,
                                        input logic [3:0] rt, input logic [3:0] rd);
    instr_t r;
    r.op = alu_op_e'(op);
    r.rs = rs;
    r.rt = rt;
    r.rd = rd;
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_fifo.sv
// Circular instruction buffer. Flush empties it and drops any push in the same
// cycle; pointers wrap naturally because DEPTH is a power of two.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == CNT_ZERO);
  assign count     = count_q;
  assign rdata     = mem_q[rd_ptr_q];
  assign do_push_s = push && !full && !flush;
  assign do_pop_s  = pop && !empty && !flush;

  // Storage write
  always_comb begin
    mem_d = mem_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = wdata;
    end else begin
      mem_d = mem_q;
    end
  end

  // Pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the register/ALU datapath: buffers instructions, then
// holds execute for EXEC_CYCLES followed by one settle cycle per instruction.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int EXEC_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  input  logic [2:0]                  instr_op,
  input  logic [3:0]                  instr_rs,
  input  logic [3:0]                  instr_rt,
  input  logic [3:0]                  instr_rd,
  input  logic                        flush,
  output logic [2:0]                  ALU_Operation,
  output logic [3:0]                  Rs,
  output logic [3:0]                  Rt,
  output logic [3:0]                  Rd,
  output logic                        execute,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]            issued_count
);

  localparam int EC_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [EC_W-1:0]  EC_LOAD   = EC_W'(EXEC_CYCLES - 1);
  localparam logic [EC_W-1:0]  EC_ONE    = EC_W'(1);
  localparam logic [EC_W-1:0]  EC_ZERO   = {EC_W{1'b0}};
  localparam logic [CNT_W-1:0] ISSUE_ONE = CNT_W'(1);

  issue_state_e       state_q, state_d;
  logic [EC_W-1:0]    exec_cnt_q, exec_cnt_d;
  instr_t             instr_q, instr_d;
  logic               execute_q, execute_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic [INSTR_W-1:0] instr_in_s, fifo_rdata_s;
  logic               fifo_full_s, fifo_empty_s;
  logic               push_s, pop_s, retire_s;

  assign instr_in_s  = pack_instr(instr_op, instr_rs, instr_rt, instr_rd);
  // Ready depends on occupancy only, so a full buffer refuses even while popping.
  assign instr_ready = !fifo_full_s;
  assign push_s      = instr_valid && !fifo_full_s;
  assign pop_s       = (state_q == ST_IDLE) && !fifo_empty_s && !flush;
  assign retire_s    = (state_q == ST_EXEC) && (exec_cnt_q == EC_ZERO);

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush),
    .wdata (instr_in_s),
    .rdata (fifo_rdata_s),
    .count (fifo_count),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (retire_s) begin
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, registered against the upcoming state
  always_comb begin
    execute_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      ST_EXEC: begin
        execute_d = 1'b1;
        busy_d    = 1'b1;
      end
      ST_SETTLE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        execute_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
      end
    endcase
  end

  // Instruction latch, execute countdown and retire counter
  always_comb begin
    instr_d    = instr_q;
    exec_cnt_d = exec_cnt_q;
    issued_d   = issued_q;
    if (pop_s) begin
      instr_d    = instr_t'(fifo_rdata_s);
      exec_cnt_d = EC_LOAD;
    end else if ((state_q == ST_EXEC) && (exec_cnt_q != EC_ZERO)) begin
      exec_cnt_d = exec_cnt_q - EC_ONE;
    end else begin
      exec_cnt_d = exec_cnt_q;
    end
    if (retire_s) begin
      issued_d = issued_q + ISSUE_ONE;
    end else begin
      issued_d = issued_q;
    end
  end

  // Datapath-facing registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= pack_instr(3'b000, 4'h0, 4'h0, 4'h0);
      exec_cnt_q <= EC_ZERO;
      issued_q   <= {CNT_W{1'b0}};
      execute_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      exec_cnt_q <= exec_cnt_d;
      issued_q   <= issued_d;
      execute_q  <= execute_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ALU_Operation = instr_q.op;
  assign Rs            = instr_q.rs;
  assign Rt            = instr_q.rt;
  assign Rd            = instr_q.rd;
  assign execute       = execute_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign issued_count  = issued_q;

endmodule
